// File: rtl/uno_seq.sv
// Command sequencer for one uno PE: streams MAC operand beats or issues Horner steps plus a
// scale/offset step, then captures the PE's registered result into a one-entry output buffer.
module uno_seq #(
  parameter int MAC_BW     = 12,
  parameter int POLY_ORDER = 3,
  parameter int LEN_W      = 8,
  parameter int CADDR_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [LEN_W-1:0]      cmd_len,
  input  logic [MAC_BW-1:0]     cmd_x,
  input  logic [MAC_BW-1:0]     cmd_y,
  input  logic [2*MAC_BW-1:0]   cmd_z,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [MAC_BW-1:0]     in_x,
  input  logic [MAC_BW-1:0]     in_y,
  output logic [1:0]            pe_op,
  output logic [MAC_BW-1:0]     pe_x,
  output logic [MAC_BW-1:0]     pe_y,
  output logic [2*MAC_BW-1:0]   pe_z,
  output logic [CADDR_W-1:0]    pe_coeff_addr,
  output logic                  pe_first_cycle,
  output logic                  pe_last_cycle,
  output logic                  pe_acc_en,
  input  logic [2*MAC_BW-1:0]   pe_result,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [2*MAC_BW-1:0]   res_data,
  output logic                  busy
);

  localparam int RW     = 2 * MAC_BW;
  localparam int KW     = CADDR_W - 2;
  localparam int STEP_W = CADDR_W - 1;
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(POLY_ORDER);

  typedef enum logic [1:0] {S_IDLE, S_MAC_RUN, S_POLY_RUN, S_DRAIN} state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_op;
  logic [LEN_W-1:0]    r_cnt;
  logic [STEP_W-1:0]   r_step;
  logic                r_started;
  logic                r_res_valid;
  logic [RW-1:0]       r_res_data;
  logic [MAC_BW-1:0]   r_x;
  logic [MAC_BW-1:0]   r_y;
  logic [RW-1:0]       r_z;

  logic w_accept;
  logic w_beat;
  logic w_cnt_zero;
  logic w_poly_last;

  // The result buffer may be emptied in the same cycle a new command is taken.
  assign cmd_ready   = (r_state == S_IDLE) & (~r_res_valid | res_ready) & ~rst;
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_cnt_zero  = (r_cnt == '0);
  assign in_ready    = (r_state == S_MAC_RUN) & ~w_cnt_zero;
  assign w_beat      = in_ready & in_valid;
  assign w_poly_last = (r_step == LAST_STEP);
  assign busy        = (r_state != S_IDLE);
  assign res_valid   = r_res_valid;
  assign res_data    = r_res_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = (cmd_op == 2'b00) ? S_MAC_RUN : S_POLY_RUN;
      end
      S_MAC_RUN: begin
        // A zero-length command still spends one cycle loading z into the PE.
        if (w_cnt_zero || (w_beat && (r_cnt == LEN_W'(1)))) w_next = S_DRAIN;
      end
      S_POLY_RUN: begin
        if (w_poly_last) w_next = S_DRAIN;
      end
      S_DRAIN: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    pe_op          = 2'b00;
    pe_x           = '0;
    pe_y           = '0;
    pe_z           = '0;
    pe_coeff_addr  = '0;
    pe_first_cycle = 1'b0;
    pe_last_cycle  = 1'b0;
    pe_acc_en      = 1'b0;
    case (r_state)
      S_MAC_RUN: begin
        pe_op     = r_op;
        pe_x      = w_beat ? in_x : '0;
        pe_y      = w_beat ? in_y : '0;
        // Before the first beat keep reloading z; afterwards idle cycles add zero.
        pe_acc_en = r_started;
        pe_z      = r_started ? '0 : r_z;
      end
      S_POLY_RUN: begin
        pe_op = r_op;
        pe_x  = r_x;
        pe_y  = r_y;
        if (w_poly_last) begin
          pe_last_cycle = 1'b1;
        end else begin
          pe_coeff_addr  = {r_op, r_step[KW-1:0]};
          pe_first_cycle = (r_step == '0);
        end
      end
      S_DRAIN: begin
        pe_op = r_op;
      end
      default: begin
        pe_op = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op      <= 2'b00;
      r_cnt     <= '0;
      r_step    <= '0;
      r_started <= 1'b0;
    end else if (w_accept) begin
      r_op      <= cmd_op;
      r_cnt     <= cmd_len;
      r_step    <= '0;
      r_started <= 1'b0;
    end else begin
      if (w_beat) begin
        r_cnt     <= r_cnt - LEN_W'(1);
        r_started <= 1'b1;
      end
      if ((r_state == S_POLY_RUN) && !w_poly_last) begin
        r_step <= r_step + STEP_W'(1);
      end
    end
  end

  // Operands only matter after an accept, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_x <= cmd_x;
      r_y <= cmd_y;
      r_z <= cmd_z;
    end
  end

  // Buffer is guaranteed empty in DRAIN because accept waited for it to free up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
    end else if (r_state == S_DRAIN) begin
      r_res_valid <= 1'b1;
      r_res_data  <= pe_result;
    end else if (r_res_valid && res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uno_seq.sv
// Bench for uno_seq: a behavioural PE closes the loop, a scoreboard queue holds expected results.
module tb_uno_seq;

  localparam int MAC_BW     = 12;
  localparam int POLY_ORDER = 3;
  localparam int LEN_W      = 8;
  localparam int CADDR_W    = 4;
  localparam int RW         = 2 * MAC_BW;

  logic                clk = 1'b0;
  logic                rst;
  logic                cmd_valid;
  logic                cmd_ready;
  logic [1:0]          cmd_op;
  logic [LEN_W-1:0]    cmd_len;
  logic [MAC_BW-1:0]   cmd_x;
  logic [MAC_BW-1:0]   cmd_y;
  logic [RW-1:0]       cmd_z;
  logic                in_valid;
  logic                in_ready;
  logic [MAC_BW-1:0]   in_x;
  logic [MAC_BW-1:0]   in_y;
  logic [1:0]          pe_op;
  logic [MAC_BW-1:0]   pe_x;
  logic [MAC_BW-1:0]   pe_y;
  logic [RW-1:0]       pe_z;
  logic [CADDR_W-1:0]  pe_coeff_addr;
  logic                pe_first_cycle;
  logic                pe_last_cycle;
  logic                pe_acc_en;
  logic [RW-1:0]       pe_result = '0;
  logic                res_valid;
  logic                res_ready;
  logic [RW-1:0]       res_data;
  logic                busy;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  logic [RW-1:0] exp_q[$];

  uno_seq #(.MAC_BW(MAC_BW), .POLY_ORDER(POLY_ORDER), .LEN_W(LEN_W), .CADDR_W(CADDR_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .cmd_x(cmd_x), .cmd_y(cmd_y), .cmd_z(cmd_z),
    .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
    .pe_op(pe_op), .pe_x(pe_x), .pe_y(pe_y), .pe_z(pe_z), .pe_coeff_addr(pe_coeff_addr),
    .pe_first_cycle(pe_first_cycle), .pe_last_cycle(pe_last_cycle), .pe_acc_en(pe_acc_en),
    .pe_result(pe_result),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Toy PE: MAC is exact; nonlinear ops use a simple recurrence the bench can predict.
  logic [RW-1:0] w_prod;
  assign w_prod = RW'(pe_x) * RW'(pe_y);
  always @(posedge clk) begin
    if (pe_op == 2'd0)       pe_result <= (pe_acc_en ? pe_result : pe_z) + w_prod;
    else if (pe_first_cycle) pe_result <= RW'(pe_coeff_addr) * RW'(100) + RW'(pe_x);
    else if (pe_last_cycle)  pe_result <= pe_result + RW'(pe_y);
    else                     pe_result <= pe_result * RW'(3) + RW'(pe_coeff_addr);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [RW-1:0] poly_ref(input logic [1:0] op, input logic [MAC_BW-1:0] x,
                                             input logic [MAC_BW-1:0] y);
    logic [RW-1:0] r;
    r = RW'(op) * RW'(4) * RW'(100) + RW'(x);
    for (int k = 1; k < POLY_ORDER; k++) r = r * RW'(3) + RW'(op) * RW'(4) + RW'(k);
    return r + RW'(y);
  endfunction

  always @(negedge clk) begin
    if (!rst && res_valid && res_ready) begin
      if (exp_q.size() == 0) chk("sb_extra_result", 64'(exp_q.size()), 64'd1);
      else chk("res_data", 64'(res_data), 64'(exp_q.pop_front()));
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [LEN_W-1:0] len, input logic [MAC_BW-1:0] x,
                       input logic [MAC_BW-1:0] y, input logic [RW-1:0] z, output int t);
    int n;
    n = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_len = len; cmd_x = x; cmd_y = y; cmd_z = z;
    #1;
    while (!cmd_ready && n < 50) begin
      next_cyc();
      #1;
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 64'(cmd_ready), 64'd1);
    t = cyc;
    next_cyc();
    cmd_valid = 1'b0;
  endtask

  task automatic beat(input logic v, input logic [MAC_BW-1:0] x, input logic [MAC_BW-1:0] y,
                      input logic exp_rdy, input logic exp_acc, input logic [RW-1:0] exp_z,
                      input string tag);
    in_valid = v; in_x = x; in_y = y;
    #1;
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(exp_rdy));
    chk({tag, "_pe_x"}, 64'(pe_x), (v && exp_rdy) ? 64'(x) : 64'd0);
    chk({tag, "_acc_en"}, 64'(pe_acc_en), 64'(exp_acc));
    if (!exp_acc) chk({tag, "_pe_z"}, 64'(pe_z), 64'(exp_z));
    next_cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int t0, input int lat, input string tag);
    int n;
    n = 0;
    while (!res_valid && n < 40) begin
      next_cyc();
      n++;
    end
    if (!res_valid) chk({tag, "_timeout"}, 64'(res_valid), 64'd1);
    else chk(tag, 64'(cyc - t0), 64'(lat));
  endtask

  task automatic poly_run(input logic [1:0] op, input logic [MAC_BW-1:0] x, input logic [MAC_BW-1:0] y);
    int t;
    exp_q.push_back(poly_ref(op, x, y));
    issue(op, '0, x, y, '0, t);
    for (int k = 0; k < POLY_ORDER; k++) begin
      #1;
      chk("poly_first", 64'(pe_first_cycle), (k == 0) ? 64'd1 : 64'd0);
      chk("poly_last", 64'(pe_last_cycle), 64'd0);
      chk("poly_addr", 64'(pe_coeff_addr), 64'(op) * 64'd4 + 64'(k));
      chk("poly_xy", {40'd0, pe_x, pe_y}, {40'd0, x, y});
      chk("poly_op_z_rdy", {pe_op, pe_z, in_ready}, {op, 24'd0, 1'b0});
      next_cyc();
    end
    #1;
    chk("scale_step", {pe_first_cycle, pe_last_cycle, pe_coeff_addr}, {2'b01, 4'd0});
    next_cyc();
    #1;
    chk("drain_pe", {pe_op, pe_x, pe_first_cycle, pe_last_cycle, pe_coeff_addr},
        {op, 12'd0, 2'b00, 4'd0});
    wait_res(t, POLY_ORDER + 3, "poly_latency");
    next_cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t;
    logic seen;
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0; cmd_x = '0; cmd_y = '0; cmd_z = '0;
    in_valid = 1'b0; in_x = '0; in_y = '0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_res", {39'd0, res_valid, res_data}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_pe", {7'd0, pe_op, pe_x, pe_y, pe_z, pe_coeff_addr, pe_first_cycle, pe_last_cycle, pe_acc_en}, 64'd0);
    rst = 1'b0;
    #1;
    chk("idle_cmd_ready", 64'(cmd_ready), 64'd1);
    next_cyc();

    // MAC, back-to-back beats: 10 + 2*3 + 4*5 + 1*1
    exp_q.push_back(RW'(37));
    issue(2'b00, 8'd3, '0, '0, RW'(10), t);
    beat(1'b1, 12'd2, 12'd3, 1'b1, 1'b0, RW'(10), "m1b1");
    beat(1'b1, 12'd4, 12'd5, 1'b1, 1'b1, '0, "m1b2");
    beat(1'b1, 12'd1, 12'd1, 1'b1, 1'b1, '0, "m1b3");
    #1;
    chk("m1_drain", {in_ready, busy}, 64'b01);
    wait_res(t, 5, "m1_latency");
    next_cyc();

    // MAC with a two-cycle gap after the first beat
    exp_q.push_back(RW'(37));
    issue(2'b00, 8'd3, '0, '0, RW'(10), t);
    beat(1'b1, 12'd2, 12'd3, 1'b1, 1'b0, RW'(10), "m2b1");
    beat(1'b0, 12'd7, 12'd7, 1'b1, 1'b1, '0, "m2gap1");
    beat(1'b0, 12'd7, 12'd7, 1'b1, 1'b1, '0, "m2gap2");
    beat(1'b1, 12'd4, 12'd5, 1'b1, 1'b1, '0, "m2b2");
    beat(1'b1, 12'd1, 12'd1, 1'b1, 1'b1, '0, "m2b3");
    wait_res(t, 7, "m2_latency");
    next_cyc();

    // MAC with a gap before the first beat: z keeps reloading
    exp_q.push_back(RW'(18));
    issue(2'b00, 8'd2, '0, '0, RW'(5), t);
    beat(1'b0, 12'd9, 12'd9, 1'b1, 1'b0, RW'(5), "m3gap");
    beat(1'b1, 12'd3, 12'd3, 1'b1, 1'b0, RW'(5), "m3b1");
    beat(1'b1, 12'd2, 12'd2, 1'b1, 1'b1, '0, "m3b2");
    wait_res(t, 5, "m3_latency");
    next_cyc();

    // Nonlinear ops
    poly_run(2'b10, 12'd7, 12'd11);
    poly_run(2'b01, 12'd100, 12'd3);
    poly_run(2'b11, 12'hFFF, 12'h800);

    // Backpressure: pending result blocks accept until res_ready rises
    res_ready = 1'b0;
    exp_q.push_back(RW'(5));
    issue(2'b00, 8'd1, '0, '0, RW'(1), t);
    beat(1'b1, 12'd2, 12'd2, 1'b1, 1'b0, RW'(1), "bpb1");
    wait_res(t, 3, "bp_latency");
    exp_q.push_back(poly_ref(2'b01, 12'd3, 12'd4));
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_x = 12'd3; cmd_y = 12'd4;
    #1;
    chk("bp_cmd_ready0", 64'(cmd_ready), 64'd0);
    next_cyc();
    #1;
    chk("bp_cmd_ready1", 64'(cmd_ready), 64'd0);
    chk("bp_hold", {39'd0, res_valid, res_data}, {39'd0, 1'b1, RW'(5)});
    res_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(cmd_ready), 64'd1);
    t = cyc;
    next_cyc();
    cmd_valid = 1'b0;
    #1;
    chk("bp_after", {res_valid, busy}, 64'b01);
    wait_res(t, POLY_ORDER + 3, "bp_poly_latency");
    next_cyc();

    // Zero-length MAC returns z untouched
    exp_q.push_back(RW'('h00ABC));
    issue(2'b00, 8'd0, '0, '0, RW'('h00ABC), t);
    #1;
    chk("len0_issue", {in_ready, pe_acc_en, pe_x, pe_z}, {2'b00, 12'd0, RW'('h00ABC)});
    seen = 1'b0;
    n = 0;
    while (!res_valid && n < 20) begin
      seen = seen | in_ready;
      next_cyc();
      #1;
      n++;
    end
    chk("len0_in_ready_seen", 64'(seen), 64'd0);
    chk("len0_done", 64'(res_valid), 64'd1);
    next_cyc();

    // Reset during the second Horner step drops everything
    issue(2'b10, '0, 12'd5, 12'd6, '0, t);
    #1;
    chk("rstmid_step0", 64'(pe_first_cycle), 64'd1);
    next_cyc();
    #1;
    chk("rstmid_step1", 64'(pe_coeff_addr), 64'd9);
    rst = 1'b1;
    next_cyc();
    #1;
    chk("rstmid_state", {res_valid, busy, cmd_ready}, 64'd0);
    chk("rstmid_pe", {7'd0, pe_op, pe_x, pe_y, pe_z, pe_coeff_addr, pe_first_cycle, pe_last_cycle, pe_acc_en}, 64'd0);
    rst = 1'b0;
    #1;
    chk("rstmid_ready", 64'(cmd_ready), 64'd1);
    next_cyc();

    // Recovery after reset
    exp_q.push_back(RW'(12));
    issue(2'b00, 8'd1, '0, '0, '0, t);
    beat(1'b1, 12'd3, 12'd4, 1'b1, 1'b0, '0, "recb1");
    wait_res(t, 3, "rec_latency");
    next_cyc();

    repeat (3) next_cyc();
    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
